// File: rtl/arbiter.sv
// Parameterised request arbiter with fixed-priority or round-robin selection,
// optional grant holding (released by acknowledge or by request drop), and
// registered one-hot, valid and binary-encoded grant outputs.
module arbiter #(
  parameter int PORTS                 = 4,
  parameter int ARB_TYPE_ROUND_ROBIN  = 0,
  parameter int ARB_BLOCK             = 0,
  parameter int ARB_BLOCK_ACK         = 1,
  parameter int ARB_LSB_HIGH_PRIORITY = 0,
  localparam int ENC_W                = (PORTS > 1) ? $clog2(PORTS) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [PORTS-1:0] request,
  input  logic [PORTS-1:0] acknowledge,
  output logic [PORTS-1:0] grant,
  output logic             grant_valid,
  output logic [ENC_W-1:0] grant_encoded
);

  // Round-robin mask: ports still eligible ahead of the last winner.
  // Stays zero in fixed-priority mode, where it is never loaded.
  logic [PORTS-1:0] mask;

  logic             hold;
  logic             hold_ack;
  logic             hold_req;
  logic [PORTS-1:0] masked;
  logic [PORTS-1:0] candidates;
  logic [ENC_W-1:0] win_idx;

  logic [PORTS-1:0] grant_next;
  logic             grant_valid_next;
  logic [ENC_W-1:0] grant_encoded_next;
  logic [PORTS-1:0] mask_next;

  // Priority encoder: lowest set index wins when LSB priority is selected,
  // otherwise the highest set index wins. Returns 0 for an empty vector.
  function automatic logic [ENC_W-1:0] prio_index(input logic [PORTS-1:0] vec);
    logic [ENC_W-1:0] idx;
    idx = '0;
    if (ARB_LSB_HIGH_PRIORITY != 0) begin
      for (int i = PORTS - 1; i >= 0; i--) begin
        if (vec[i]) idx = ENC_W'(i);
      end
    end else begin
      for (int i = 0; i < PORTS; i++) begin
        if (vec[i]) idx = ENC_W'(i);
      end
    end
    return idx;
  endfunction

  // Binary index to one-hot vector.
  function automatic logic [PORTS-1:0] index_onehot(input logic [ENC_W-1:0] idx);
    logic [PORTS-1:0] oh;
    oh = '0;
    for (int j = 0; j < PORTS; j++) begin
      oh[j] = (ENC_W'(j) == idx);
    end
    return oh;
  endfunction

  // Mask after granting port idx: only ports "behind" the winner in the
  // priority direction remain preferred on the next arbitration.
  function automatic logic [PORTS-1:0] rr_mask(input logic [ENC_W-1:0] idx);
    logic [PORTS-1:0] m;
    m = '0;
    for (int j = 0; j < PORTS; j++) begin
      if (ARB_LSB_HIGH_PRIORITY != 0) m[j] = (j > int'(idx));
      else                            m[j] = (j < int'(idx));
    end
    return m;
  endfunction

  // Hold decision, winner selection and next-state computation.
  always_comb begin
    hold_ack = grant_valid && ((grant & acknowledge) == '0);
    hold_req = (grant & request) != '0;
    hold     = (ARB_BLOCK != 0) && ((ARB_BLOCK_ACK != 0) ? hold_ack : hold_req);

    masked     = request & mask;
    candidates = ((ARB_TYPE_ROUND_ROBIN != 0) && (masked != '0)) ? masked : request;
    win_idx    = prio_index(candidates);

    grant_next         = grant;
    grant_valid_next   = grant_valid;
    grant_encoded_next = grant_encoded;
    mask_next          = mask;

    if (!hold) begin
      if (request != '0) begin
        grant_next         = index_onehot(win_idx);
        grant_valid_next   = 1'b1;
        grant_encoded_next = win_idx;
        if (ARB_TYPE_ROUND_ROBIN != 0) mask_next = rr_mask(win_idx);
      end else begin
        grant_next         = '0;
        grant_valid_next   = 1'b0;
        grant_encoded_next = '0;
      end
    end
  end

  // Grant registers and round-robin mask; reset clears everything at once.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      grant         <= '0;
      grant_valid   <= 1'b0;
      grant_encoded <= '0;
      mask          <= '0;
    end else begin
      grant         <= grant_next;
      grant_valid   <= grant_valid_next;
      grant_encoded <= grant_encoded_next;
      mask          <= mask_next;
    end
  end

endmodule

// File: tb/tb_arbiter.sv
// Bench for arbiter: several parameterisations share one stimulus stream and
// are compared every cycle with a pointer-based behavioural model, plus
// directed checks of the documented example sequences.
module tb_arbiter;
  localparam int N = 7;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [3:0] req;
  logic [3:0] ack;

  logic [3:0] g_out [6];
  logic       v_out [6];
  logic [1:0] e_out [6];
  logic       g1, v1, e1;

  // configuration of each instance, in instance order
  int c_p   [N] = '{4, 4, 4, 4, 4, 4, 1};
  int c_rr  [N] = '{0, 0, 1, 1, 0, 1, 1};
  int c_lsb [N] = '{1, 0, 1, 1, 1, 0, 0};
  int c_blk [N] = '{0, 0, 0, 1, 1, 1, 1};
  int c_ack [N] = '{1, 1, 1, 1, 0, 0, 1};

  // model state: granted index (-1 none) and last newly granted index (-1 none)
  int m_g    [N];
  int m_last [N];

  int total = 0;
  int bad   = 0;

  arbiter #(.PORTS(4), .ARB_TYPE_ROUND_ROBIN(0), .ARB_BLOCK(0), .ARB_BLOCK_ACK(1), .ARB_LSB_HIGH_PRIORITY(1))
    u_fix_lsb (.clk(clk), .rst(rst), .request(req), .acknowledge(ack), .grant(g_out[0]), .grant_valid(v_out[0]), .grant_encoded(e_out[0]));
  arbiter #(.PORTS(4), .ARB_TYPE_ROUND_ROBIN(0), .ARB_BLOCK(0), .ARB_BLOCK_ACK(1), .ARB_LSB_HIGH_PRIORITY(0))
    u_fix_msb (.clk(clk), .rst(rst), .request(req), .acknowledge(ack), .grant(g_out[1]), .grant_valid(v_out[1]), .grant_encoded(e_out[1]));
  arbiter #(.PORTS(4), .ARB_TYPE_ROUND_ROBIN(1), .ARB_BLOCK(0), .ARB_BLOCK_ACK(1), .ARB_LSB_HIGH_PRIORITY(1))
    u_rr_lsb (.clk(clk), .rst(rst), .request(req), .acknowledge(ack), .grant(g_out[2]), .grant_valid(v_out[2]), .grant_encoded(e_out[2]));
  arbiter #(.PORTS(4), .ARB_TYPE_ROUND_ROBIN(1), .ARB_BLOCK(1), .ARB_BLOCK_ACK(1), .ARB_LSB_HIGH_PRIORITY(1))
    u_rr_ack (.clk(clk), .rst(rst), .request(req), .acknowledge(ack), .grant(g_out[3]), .grant_valid(v_out[3]), .grant_encoded(e_out[3]));
  arbiter #(.PORTS(4), .ARB_TYPE_ROUND_ROBIN(0), .ARB_BLOCK(1), .ARB_BLOCK_ACK(0), .ARB_LSB_HIGH_PRIORITY(1))
    u_blk_req (.clk(clk), .rst(rst), .request(req), .acknowledge(ack), .grant(g_out[4]), .grant_valid(v_out[4]), .grant_encoded(e_out[4]));
  arbiter #(.PORTS(4), .ARB_TYPE_ROUND_ROBIN(1), .ARB_BLOCK(1), .ARB_BLOCK_ACK(0), .ARB_LSB_HIGH_PRIORITY(0))
    u_rr_msb (.clk(clk), .rst(rst), .request(req), .acknowledge(ack), .grant(g_out[5]), .grant_valid(v_out[5]), .grant_encoded(e_out[5]));
  arbiter #(.PORTS(1), .ARB_TYPE_ROUND_ROBIN(1), .ARB_BLOCK(1), .ARB_BLOCK_ACK(1), .ARB_LSB_HIGH_PRIORITY(0))
    u_one (.clk(clk), .rst(rst), .request(req[0:0]), .acknowledge(ack[0:0]), .grant(g1), .grant_valid(v1), .grant_encoded(e1));

  function automatic logic [3:0] obs_g(int i);
    return (i == 6) ? {3'b000, g1} : g_out[i];
  endfunction

  function automatic logic [3:0] obs_v(int i);
    return (i == 6) ? {3'b000, v1} : {3'b000, v_out[i]};
  endfunction

  function automatic logic [3:0] obs_e(int i);
    return (i == 6) ? {3'b000, e1} : {2'b00, e_out[i]};
  endfunction

  // Winner selection: round-robin scans onward from the last winner in the
  // priority direction, then falls back to plain priority over all requests.
  function automatic int pick(int i, int rm);
    int p;
    p = c_p[i];
    if (c_rr[i] != 0 && m_last[i] >= 0) begin
      if (c_lsb[i] != 0) begin
        for (int j = m_last[i] + 1; j < p; j++) if (rm[j]) return j;
      end else begin
        for (int j = m_last[i] - 1; j >= 0; j--) if (rm[j]) return j;
      end
    end
    if (c_lsb[i] != 0) begin
      for (int j = 0; j < p; j++) if (rm[j]) return j;
    end else begin
      for (int j = p - 1; j >= 0; j--) if (rm[j]) return j;
    end
    return -1;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_g[i]    = -1;
      m_last[i] = -1;
    end
  endtask

  task automatic model_step();
    for (int i = 0; i < N; i++) begin
      int pm, rm, am, g;
      bit held;
      pm   = (1 << c_p[i]) - 1;
      rm   = int'(req) & pm;
      am   = int'(ack) & pm;
      g    = m_g[i];
      held = 1'b0;
      if (c_blk[i] != 0 && g >= 0) held = (c_ack[i] != 0) ? !am[g] : rm[g];
      if (!held) begin
        if (rm != 0) begin
          g         = pick(i, rm);
          m_last[i] = g;
        end else begin
          g = -1;
        end
      end
      m_g[i] = g;
    end
  endtask

  task automatic chk(string tag, int i, logic [3:0] obs, logic [3:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s inst%0d observed=%b expected=%b", tag, i, obs, exp);
    end
  endtask

  task automatic check_model();
    for (int i = 0; i < N; i++) begin
      logic [3:0] eg, ev, ee;
      eg = (m_g[i] >= 0) ? 4'(1 << m_g[i]) : 4'b0000;
      ev = (m_g[i] >= 0) ? 4'b0001 : 4'b0000;
      ee = (m_g[i] >= 0) ? 4'(m_g[i]) : 4'b0000;
      chk("grant", i, obs_g(i), eg);
      chk("valid", i, obs_v(i), ev);
      chk("encoded", i, obs_e(i), ee);
    end
  endtask

  // one rising edge: model consumes the inputs seen at the edge, then compare
  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check_model();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    #1;
    check_model();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  logic [3:0] rr_seq [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

  initial begin
    rst = 1'b0;
    req = 4'b0000;
    ack = 4'b0000;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_model();
    @(negedge clk);
    rst = 1'b1;

    // fixed priority, both directions
    req = 4'b1010;
    tick();
    chk("fix_lsb_grant", 0, obs_g(0), 4'b0010);
    chk("fix_lsb_enc", 0, obs_e(0), 4'b0001);
    chk("fix_lsb_valid", 0, obs_v(0), 4'b0001);
    chk("fix_msb_grant", 1, obs_g(1), 4'b1000);
    req = 4'b0110;
    tick();
    chk("fix_msb_grant2", 1, obs_g(1), 4'b0100);
    chk("fix_msb_enc2", 1, obs_e(1), 4'b0010);
    req = 4'b0000;
    tick();
    chk("fix_lsb_idle", 0, obs_g(0), 4'b0000);
    chk("fix_lsb_idle_valid", 0, obs_v(0), 4'b0000);

    // round-robin rotation and acknowledge-held grant
    do_reset();
    req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("rr_rotate", 2, obs_g(2), rr_seq[k]);
      if (k == 0) chk("rr_ack_first", 3, obs_g(3), 4'b0001);
    end
    req = 4'b0000;
    ack = 4'b0000;
    tick();
    chk("rr_ack_hold", 3, obs_g(3), 4'b0001);
    ack = 4'b0001;
    req = 4'b1001;
    tick();
    chk("rr_ack_release", 3, obs_g(3), 4'b1000);
    ack = 4'b0000;

    // hold while the granted request stays high
    do_reset();
    req = 4'b1100;
    tick();
    chk("blk_req_first", 4, obs_g(4), 4'b0100);
    req = 4'b1101;
    tick();
    chk("blk_req_hold", 4, obs_g(4), 4'b0100);
    req = 4'b1001;
    tick();
    chk("blk_req_switch", 4, obs_g(4), 4'b0001);

    // asynchronous reset in the middle of a grant
    req = 4'b0100;
    tick();
    chk("pre_reset_grant", 4, obs_g(4), 4'b0100);
    #2;
    rst = 1'b0;
    model_reset();
    #1;
    chk("async_reset_grant", 4, obs_g(4), 4'b0000);
    check_model();
    req = 4'b1000;
    @(negedge clk);
    rst = 1'b1;
    tick();
    chk("post_reset_fix", 0, obs_g(0), 4'b1000);
    chk("post_reset_blk", 4, obs_g(4), 4'b1000);

    // randomised traffic against the model
    for (int n = 0; n < 400; n++) begin
      req = ($urandom_range(0, 5) == 0) ? 4'b0000 : 4'($urandom);
      ack = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'b0000;
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/arbiter.md
ARBITER -- requirements
Module: arbiter

Interface
REQ-001 Parameter PORTS, default 4: number of requesters, >= 1.
REQ-002 Parameter ARB_TYPE_ROUND_ROBIN, default 0: 0 = fixed priority, 1 = round-robin.
REQ-003 Parameter ARB_BLOCK, default 0: 1 = hold the current grant until it is released.
REQ-004 Parameter ARB_BLOCK_ACK, default 1: with ARB_BLOCK=1, release on acknowledge (1) or on request drop (0).
REQ-005 Parameter ARB_LSB_HIGH_PRIORITY, default 0: 1 = lowest index wins, 0 = highest index wins.
REQ-006 clk  input  1  sole clock; all state on rising edge.
REQ-007 rst  input  1  reset; one clock; asynchronous and active-low (asserted at 0).
REQ-008 request  input  PORTS  per-port request, level-sensitive.
REQ-009 acknowledge  input  PORTS  per-port release of the held grant (used only when ARB_BLOCK=1 and ARB_BLOCK_ACK=1).
REQ-010 grant  output  PORTS  registered one-hot grant, all-zero when none.
REQ-011 grant_valid  output  1  registered; 1 when grant is non-zero.
REQ-012 grant_encoded  output  max(1,clog2(PORTS))  registered binary index of the granted port; 0 when none.

Function
REQ-013 All outputs SHALL be registered, with one-cycle latency from request or acknowledge to grant.
REQ-014 grant SHALL be one-hot or zero.
- grant_valid SHALL equal |grant.
- grant_encoded SHALL match grant.
REQ-015 Hold rule, ARB_BLOCK=1 and ARB_BLOCK_ACK=0: while (grant & request) != 0, the grant SHALL be kept unchanged.
REQ-016 Hold rule, ARB_BLOCK=1 and ARB_BLOCK_ACK=1: while grant_valid=1 and (grant & acknowledge)=0, the grant SHALL be kept, even if request drops.
REQ-017 Re-arbitration SHALL occur each cycle the hold rule does not apply.
- If request is non-zero, a new grant SHALL be computed.
- Otherwise the next state SHALL be grant=0, grant_valid=0, grant_encoded=0.
REQ-018 Fixed priority: the winner SHALL be the lowest-index set request bit (ARB_LSB_HIGH_PRIORITY=1) or the highest-index one (0).
REQ-019 Round-robin SHALL keep a PORTS-bit mask register.
- The winner SHALL be the priority-encoded (request & mask) if non-zero; otherwise the priority-encoded request.
REQ-020 On each new round-robin grant to index k, the mask SHALL be updated:
- ARB_LSB_HIGH_PRIORITY=1: bits > k set, others clear.
- ARB_LSB_HIGH_PRIORITY=0: bits < k set, others clear.
- The mask SHALL be unchanged while a grant is held or when there is no request.
REQ-021 With ARB_BLOCK=0, arbitration SHALL occur every cycle; in round-robin mode the grant rotates among continuously asserted requests.
REQ-022 Acknowledge on a non-granted port SHALL be ignored. Acknowledge on the granted port SHALL release the grant, and re-arbitration in that same cycle SHALL apply masked priority.
REQ-023 A simultaneous release and new requests SHALL produce the new grant on the next edge, with no idle cycle.
REQ-024 With PORTS=1:
- grant SHALL follow the hold and request rules.
- grant_encoded SHALL be constant 0.

Reset
REQ-025 While rst=0, asynchronously:
- grant=0, grant_valid=0, grant_encoded=0.
- round-robin mask SHALL be 0.
REQ-026 Reset asserted mid-grant SHALL drop the grant immediately.
- After rst releases, the first arbitration SHALL occur on the first rising edge with rst=1 and use the unmasked priority.
REQ-027 No output SHALL be X after reset.

Verification
REQ-028 PORTS=4, fixed priority, LSB=1, ARB_BLOCK=0: request=4'b1010.
- Next cycle: grant=0010, grant_encoded=1, grant_valid=1.
- With request=0: next cycle grant=0, grant_valid=0.
REQ-029 PORTS=4, LSB=0, fixed priority: request=4'b0110 -> grant=0100, grant_encoded=2.
REQ-030 PORTS=4, round-robin, LSB=1, ARB_BLOCK=0, request=4'b1111 held -> grant sequence 0001, 0010, 0100, 1000, 0001.
REQ-031 PORTS=4, round-robin, ARB_BLOCK=1, ARB_BLOCK_ACK=1, LSB=1: request=1111 -> grant=0001.
- With acknowledge=0 and request dropped to 0: grant stays 0001.
- acknowledge=0001 with request=1001 -> grant=1000 next cycle.
REQ-032 ARB_BLOCK=1, ARB_BLOCK_ACK=0, fixed, LSB=1: request=1100 -> grant=0100.
- Then request=1101: grant stays 0100.
- Then request=1001: grant=0001.
REQ-033 Drive rst=0 between clock edges while grant=0100: outputs go to 0 before the next edge. After release, request=1000 -> grant=1000 on the first edge.
